// File: rtl/clk_reset_sequencer.sv
// Staged reset release for the clk_core domain: synchronises the PLL lock flag, waits for a
// stable lock, then frees SDRAM, GPU and video resets in order; any lock loss re-asserts all.
module clk_reset_sequencer #(
    parameter int SYNC_STAGES          = 2,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int SDRAM_TIMEOUT_CYCLES = 30000,
    parameter int STAGE_GAP_CYCLES     = 16,
    parameter int LOSS_CNT_W           = 8
) (
    input  logic                  clk_core,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  sdram_init_done,
    output logic                  rst_sdram,
    output logic                  rst_gpu,
    output logic                  rst_video,
    output logic                  seq_ready,
    output logic                  init_timeout,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int MAX_LS     = (LOCK_STABLE_CYCLES > SDRAM_TIMEOUT_CYCLES) ?
                                LOCK_STABLE_CYCLES : SDRAM_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_LS > STAGE_GAP_CYCLES) ? MAX_LS : STAGE_GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SDRAM_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_SDRAM_INIT = 3'd1,
        ST_GPU_GAP    = 3'd2,
        ST_VIDEO_GAP  = 3'd3,
        ST_RUN        = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    rst_sdram_q, rst_sdram_d;
    logic                    rst_gpu_q, rst_gpu_d;
    logic                    rst_video_q, rst_video_d;
    logic                    seq_ready_q, seq_ready_d;
    logic                    init_timeout_q, init_timeout_d;
    logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic                    lock_s;
    logic                    lock_lost;

    // Lock synchroniser: each stage takes the previous one, stage 0 takes the raw PLL flag.
    assign sync_d[0] = pll_locked;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign lock_lost = !lock_s && (state_q != ST_WAIT_LOCK);

    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= '0;
            sync_q         <= '0;
            rst_sdram_q    <= 1'b1;
            rst_gpu_q      <= 1'b1;
            rst_video_q    <= 1'b1;
            seq_ready_q    <= 1'b0;
            init_timeout_q <= 1'b0;
            loss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            rst_sdram_q    <= rst_sdram_d;
            rst_gpu_q      <= rst_gpu_d;
            rst_video_q    <= rst_video_d;
            seq_ready_q    <= seq_ready_d;
            init_timeout_q <= init_timeout_d;
            loss_cnt_q     <= loss_cnt_d;
        end
    end

    // Next state and shared cycle counter; lock loss overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (lock_lost) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = ST_SDRAM_INIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SDRAM_INIT: begin
                    if (sdram_init_done || (cnt_q == TIMEOUT_LAST)) begin
                        state_d = ST_GPU_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GPU_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_VIDEO_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_VIDEO_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Registered outputs change on the same edge as the transition that owns them.
    always_comb begin
        rst_sdram_d    = rst_sdram_q;
        rst_gpu_d      = rst_gpu_q;
        rst_video_d    = rst_video_q;
        seq_ready_d    = seq_ready_q;
        init_timeout_d = init_timeout_q;
        loss_cnt_d     = loss_cnt_q;
        if (lock_lost) begin
            rst_sdram_d    = 1'b1;
            rst_gpu_d      = 1'b1;
            rst_video_d    = 1'b1;
            seq_ready_d    = 1'b0;
            init_timeout_d = 1'b0;
            if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
                loss_cnt_d = loss_cnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s && (cnt_q == LOCK_LAST)) begin
                        rst_sdram_d = 1'b0;
                    end
                end
                ST_SDRAM_INIT: begin
                    // A same-cycle done means the init succeeded, so no timeout flag.
                    if (!sdram_init_done && (cnt_q == TIMEOUT_LAST)) begin
                        init_timeout_d = 1'b1;
                    end
                end
                ST_GPU_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_gpu_d = 1'b0;
                    end
                end
                ST_VIDEO_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_video_d = 1'b0;
                        seq_ready_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rst_sdram       = rst_sdram_q;
    assign rst_gpu         = rst_gpu_q;
    assign rst_video       = rst_video_q;
    assign seq_ready       = seq_ready_q;
    assign init_timeout    = init_timeout_q;
    assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Directed bench for clk_reset_sequencer: inputs change 1 ns after a rising edge, outputs are
// read 1 ns after the edge under test; stat = {rst_sdram, rst_gpu, rst_video, seq_ready, init_timeout}.
module tb_clk_reset_sequencer;

    logic       clk_core = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       sdram_init_done;
    logic       rst_sdram;
    logic       rst_gpu;
    logic       rst_video;
    logic       seq_ready;
    logic       init_timeout;
    logic [7:0] lock_loss_count;
    logic [4:0] stat;

    int errors = 0;
    int checks = 0;

    clk_reset_sequencer #(
        .SYNC_STAGES         (2),
        .LOCK_STABLE_CYCLES  (8),
        .SDRAM_TIMEOUT_CYCLES(32),
        .STAGE_GAP_CYCLES    (4),
        .LOSS_CNT_W          (8)
    ) dut (
        .clk_core       (clk_core),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .sdram_init_done(sdram_init_done),
        .rst_sdram      (rst_sdram),
        .rst_gpu        (rst_gpu),
        .rst_video      (rst_video),
        .seq_ready      (seq_ready),
        .init_timeout   (init_timeout),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk_core = ~clk_core;

    assign stat = {rst_sdram, rst_gpu, rst_video, seq_ready, init_timeout};

    task automatic step(input int n);
        repeat (n) @(posedge clk_core);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst             = 1'b1;
        pll_locked      = 1'b0;
        sdram_init_done = 1'b0;

        // Reset state
        step(3);
        check("reset_stat", {3'b000, stat}, 8'h1C);
        check("reset_loss", lock_loss_count, 8'd0);

        // Normal boot: lock_s first seen at edge 3 after rst drops, 8th stable edge is edge 10
        pll_locked = 1'b1;
        step(1);
        rst = 1'b0;
        step(9);
        check("boot_pre_sdram", {3'b000, stat}, 8'h1C);
        step(1);
        check("boot_sdram_rel", {3'b000, stat}, 8'h0C);
        step(9);
        check("boot_pre_done", {3'b000, stat}, 8'h0C);
        sdram_init_done = 1'b1;
        step(1);
        check("boot_done_edge", {3'b000, stat}, 8'h0C);
        step(3);
        check("boot_pre_gpu", {3'b000, stat}, 8'h0C);
        step(1);
        check("boot_gpu_rel", {3'b000, stat}, 8'h04);
        step(3);
        check("boot_pre_video", {3'b000, stat}, 8'h04);
        step(1);
        check("boot_run", {3'b000, stat}, 8'h02);
        check("boot_loss", lock_loss_count, 8'd0);

        // Loss in RUN: resets re-assert after the third edge following the drop
        pll_locked      = 1'b0;
        sdram_init_done = 1'b0;
        step(2);
        check("loss_pre", {3'b000, stat}, 8'h02);
        step(1);
        check("loss_assert", {3'b000, stat}, 8'h1C);
        check("loss_count1", lock_loss_count, 8'd1);

        // Relock with no done: SDRAM release, then timeout exactly 32 edges later
        pll_locked = 1'b1;
        step(9);
        check("relock_pre", {3'b000, stat}, 8'h1C);
        step(1);
        check("relock_sdram", {3'b000, stat}, 8'h0C);
        step(31);
        check("tmo_pre", {3'b000, stat}, 8'h0C);
        step(1);
        check("tmo_flag", {3'b000, stat}, 8'h0D);
        step(3);
        check("tmo_pre_gpu", {3'b000, stat}, 8'h0D);
        step(1);
        check("tmo_gpu_rel", {3'b000, stat}, 8'h05);
        step(4);
        check("tmo_run", {3'b000, stat}, 8'h03);
        check("tmo_loss", lock_loss_count, 8'd1);

        // Second loss, then rst in SDRAM_INIT clears everything
        pll_locked = 1'b0;
        step(3);
        check("loss_count2", lock_loss_count, 8'd2);
        check("loss2_stat", {3'b000, stat}, 8'h1C);
        pll_locked = 1'b1;
        step(10);
        check("midinit_sdram", {3'b000, stat}, 8'h0C);
        step(5);
        rst = 1'b1;
        step(1);
        check("rst_stat", {3'b000, stat}, 8'h1C);
        check("rst_loss", lock_loss_count, 8'd0);
        step(2);
        check("rst_hold", {3'b000, stat}, 8'h1C);
        rst = 1'b0;
        step(9);
        check("reseq_pre", {3'b000, stat}, 8'h1C);
        step(1);
        check("reseq_sdram", {3'b000, stat}, 8'h0C);

        // Done arrives on the same edge as the timeout: done wins
        step(31);
        check("coinc_pre", {3'b000, stat}, 8'h0C);
        sdram_init_done = 1'b1;
        step(1);
        check("coinc_edge", {3'b000, stat}, 8'h0C);
        step(4);
        check("coinc_gpu", {3'b000, stat}, 8'h04);
        sdram_init_done = 1'b0;

        // Lock glitch during WAIT_LOCK restarts the stability count
        rst        = 1'b1;
        pll_locked = 1'b0;
        step(2);
        rst        = 1'b0;
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(4);
        check("glitch_no_rel", {3'b000, stat}, 8'h1C);
        step(5);
        check("glitch_pre", {3'b000, stat}, 8'h1C);
        step(1);
        check("glitch_rel", {3'b000, stat}, 8'h0C);
        check("glitch_loss", lock_loss_count, 8'd0);

        // Repeated losses from SDRAM_INIT: count saturates at 255
        for (int i = 0; i < 3; i++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            step(10);
        end
        check("sat_count3", lock_loss_count, 8'd3);
        for (int i = 0; i < 252; i++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            step(10);
        end
        check("sat_count255", lock_loss_count, 8'd255);
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            step(10);
        end
        check("sat_hold", lock_loss_count, 8'd255);
        check("sat_stat", {3'b000, stat}, 8'h0C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
